// File: rtl/cpucr_pkg.sv
// Shared CPUCR types and constants: bus widths, reset vector and the
// prefetch queue entry layout.
package cpucr_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

  // One fetched byte tagged with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/cpucr_prefetch_if.sv
// Bundle of memory-side and decoder-side signals of the prefetch stage.
// The prefetch block is the master; memory, arbiter and decoder form the slave.
interface cpucr_prefetch_if;
  import cpucr_pkg::*;

  logic [ADDR_W-1:0] Direccion;
  logic [DATA_W-1:0] Datos;
  logic              bus_req;
  logic              bus_gnt;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic [ADDR_W-1:0] byte_addr;
  logic              byte_pop;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              halted;

  modport master (
    output Direccion, bus_req, byte_valid, byte_data, byte_addr, halted,
    input  Datos, bus_gnt, byte_pop, redirect, redirect_pc, halt
  );

  modport slave (
    input  Direccion, bus_req, byte_valid, byte_data, byte_addr, halted,
    output Datos, bus_gnt, byte_pop, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/cpucr_byte_fifo.sv
// Small byte queue of fetch entries with synchronous push/pop/flush and an
// unregistered head read so a pushed byte is visible the following cycle.
module cpucr_byte_fifo
  import cpucr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  // Flush wins over both operations; overflow/underflow requests are dropped.
  assign push_ok = push & ~flush & ~full;
  assign pop_ok  = pop & ~flush & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset: entries beyond the count are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_entry;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/cpucr_prefetch.sv
// CPUCR instruction prefetch: walks fetch_pc over memory whenever the bus is
// granted, queues {addr, byte} pairs for the decoder, handles redirect/halt.
module cpucr_prefetch
  import cpucr_pkg::*;
#(
  parameter int                   DEPTH    = 4,
  parameter int                   ADDR_W   = cpucr_pkg::ADDR_W,
  parameter int                   DATA_W   = cpucr_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = cpucr_pkg::RESET_VECTOR
) (
  input  logic                 clk,
  input  logic                 reset,
  cpucr_prefetch_if.master     bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic              halted_reg, halted_next;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;

  logic              req;
  logic              fire;
  logic              push;
  logic              pop;
  logic              byte_valid;

  // Request depends on registered state only, so the arbiter sees no
  // combinational path back from its own grant or from the decoder.
  assign req        = ~halted_reg & ~fifo_full;
  assign fire       = req & bus.bus_gnt;
  assign push       = fire & ~bus.redirect;
  assign byte_valid = (fifo_count != '0);
  assign pop        = byte_valid & bus.byte_pop;

  assign push_entry.addr = fetch_pc_reg;
  assign push_entry.data = bus.Datos;

  cpucr_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (fifo_count),
    .head       (fifo_head),
    .full       (fifo_full)
  );

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    halted_next   = halted_reg;
    if (bus.redirect) begin
      fetch_pc_next = bus.redirect_pc;
      halted_next   = 1'b0;
    end else begin
      if (fire)     fetch_pc_next = fetch_pc_reg + 1'b1;
      if (bus.halt) halted_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      halted_reg   <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      halted_reg   <= halted_next;
    end
  end

  assign bus.Direccion  = fetch_pc_reg;
  assign bus.bus_req    = req;
  assign bus.byte_valid = byte_valid;
  assign bus.byte_data  = fifo_head.data;
  assign bus.byte_addr  = fifo_head.addr;
  assign bus.halted     = halted_reg;

endmodule

// File: tb/tb_cpucr_prefetch.sv
// Directed bench for cpucr_prefetch with a pop-side scoreboard monitor.
module tb_cpucr_prefetch;
  import cpucr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpucr_prefetch_if bus ();

  cpucr_prefetch #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory image: a few directed locations, a simple pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: mem_byte = 8'h10;
      16'h0001: mem_byte = 8'h01;
      16'h0002: mem_byte = 8'h20;
      16'h0003: mem_byte = 8'h30;
      16'hFF00: mem_byte = 8'h2F;
      default:  mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign bus.Datos = mem_byte(bus.Direccion);

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Run until the scoreboard is empty, optionally toggling the grant.
  task automatic drain(input int bound, input bit toggle_gnt);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      if (toggle_gnt) bus.bus_gnt = ~bus.bus_gnt;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_left required=0_left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every consumed head byte is checked against the scoreboard.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.byte_valid && bus.byte_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=%0h@%0h required=none",
                   bus.byte_data, bus.byte_addr);
        end else begin
          e = exp_q.pop_front();
          chk("pop_addr", 32'(bus.byte_addr), 32'(e[23:8]));
          chk("pop_data", 32'(bus.byte_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.bus_gnt     = 1'b1;
    bus.byte_pop    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt        = 1'b0;
    tick();
    tick();
    chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst_bus_req",    32'(bus.bus_req),    32'd1);
    chk("rst_direccion",  32'(bus.Direccion),  32'h0000);
    chk("rst_halted",     32'(bus.halted),     32'd0);
    reset = 1'b0;

    // Fill to full with no pops.
    repeat (4) tick();
    chk("full_bus_req",   32'(bus.bus_req),    32'd0);
    chk("full_direccion", 32'(bus.Direccion),  32'h0004);
    chk("full_head_data", 32'(bus.byte_data),  32'h10);
    chk("full_head_addr", 32'(bus.byte_addr),  32'h0000);
    tick();
    chk("full_hold_dir",  32'(bus.Direccion),  32'h0004);

    // Single pop at full, then refill of 0004.
    expect_byte(16'h0000, 8'h10);
    bus.byte_pop = 1'b1;
    tick();
    bus.byte_pop = 1'b0;
    chk("afterpop_bus_req", 32'(bus.bus_req),   32'd1);
    chk("afterpop_head",    32'(bus.byte_data), 32'h01);
    chk("afterpop_addr",    32'(bus.byte_addr), 32'h0001);
    tick();
    chk("refill_bus_req",   32'(bus.bus_req),   32'd0);
    chk("refill_dir",       32'(bus.Direccion), 32'h0005);
    chk("refill_head_addr", 32'(bus.byte_addr), 32'h0001);

    // Steady streaming, 7th pop lands in the redirect cycle.
    expect_byte(16'h0001, 8'h01);
    expect_byte(16'h0002, 8'h20);
    expect_byte(16'h0003, 8'h30);
    expect_byte(16'h0004, 8'h5E);
    expect_byte(16'h0005, 8'h5F);
    expect_byte(16'h0006, 8'h5C);
    expect_byte(16'h0007, 8'h5D);
    bus.byte_pop = 1'b1;
    repeat (6) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFF00;
    tick();
    bus.redirect = 1'b0;
    bus.byte_pop = 1'b0;
    chk("redir_byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("redir_dir",        32'(bus.Direccion),  32'hFF00);
    chk("redir_bus_req",    32'(bus.bus_req),    32'd1);
    chk("redir_sb_empty",   32'(exp_q.size()),   32'd0);
    tick();
    chk("redir_first_valid", 32'(bus.byte_valid), 32'd1);
    chk("redir_first_addr",  32'(bus.byte_addr),  32'hFF00);
    chk("redir_first_data",  32'(bus.byte_data),  32'h2F);
    expect_byte(16'hFF00, 8'h2F);
    bus.byte_pop = 1'b1;
    tick();

    // Address wrap at the top of memory.
    bus.byte_pop    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    expect_byte(16'hFFFE, 8'h5B);
    expect_byte(16'hFFFF, 8'h5A);
    expect_byte(16'h0000, 8'h10);
    expect_byte(16'h0001, 8'h01);
    bus.byte_pop = 1'b1;
    drain(20, 1'b0);
    bus.byte_pop = 1'b0;

    // Halt with two bytes queued; the fire in the halt cycle completes.
    tick();
    chk("prehalt_dir", 32'(bus.Direccion), 32'h0004);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("halt_flag",    32'(bus.halted),    32'd1);
    chk("halt_bus_req", 32'(bus.bus_req),   32'd0);
    chk("halt_dir",     32'(bus.Direccion), 32'h0005);
    expect_byte(16'h0002, 8'h20);
    expect_byte(16'h0003, 8'h30);
    expect_byte(16'h0004, 8'h5E);
    bus.byte_pop = 1'b1;
    drain(20, 1'b0);
    bus.byte_pop = 1'b0;
    chk("halted_empty",   32'(bus.byte_valid), 32'd0);
    chk("halted_bus_req", 32'(bus.bus_req),    32'd0);
    chk("halted_sticky",  32'(bus.halted),     32'd1);
    chk("halted_dir",     32'(bus.Direccion),  32'h0005);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0005;
    tick();
    bus.redirect = 1'b0;
    chk("resume_halted",  32'(bus.halted),  32'd0);
    chk("resume_bus_req", 32'(bus.bus_req), 32'd1);
    chk("resume_dir",     32'(bus.Direccion), 32'h0005);

    // Alternating grant: no duplicated or skipped addresses.
    expect_byte(16'h0005, 8'h5F);
    expect_byte(16'h0006, 8'h5C);
    expect_byte(16'h0007, 8'h5D);
    expect_byte(16'h0008, 8'h52);
    expect_byte(16'h0009, 8'h53);
    expect_byte(16'h000A, 8'h50);
    bus.bus_gnt  = 1'b0;
    bus.byte_pop = 1'b1;
    drain(40, 1'b1);
    bus.byte_pop = 1'b0;
    bus.bus_gnt  = 1'b1;

    // Reset in mid-stream discards queued bytes and restarts at RESET_PC.
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("midrst_bus_req",    32'(bus.bus_req),    32'd1);
    chk("midrst_dir",        32'(bus.Direccion),  32'h0000);
    reset = 1'b0;
    expect_byte(16'h0000, 8'h10);
    expect_byte(16'h0001, 8'h01);
    bus.byte_pop = 1'b1;
    drain(20, 1'b0);
    bus.byte_pop = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpucr_prefetch.md
Name: cpucr_prefetch

Overview:
- Instruction prefetch stage of the CPUCR core, directly upstream of the main memory.
- Drives the 16-bit memory address, captures opcode and operand bytes from the 8-bit memory data bus, and queues them for the decoder.
- Memory read data is combinational: data for the address driven in a cycle is valid on the bus before the next rising edge.
- The top level holds LE high (read) whenever this block owns the bus.

Parameters:
- DEPTH, 4, byte queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset
- ADDR_W, 16, address width (fixed by the CPUCR bus)
- DATA_W, 8, data width (fixed by the CPUCR bus)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Direccion  out  16  fetch address toward memory; equals fetch_pc at all times
- Datos  in  8  memory read data, sampled on the rising edge when a fetch fires
- bus_req  out  1  prefetch wants the bus this cycle
- bus_gnt  in  1  arbiter grant; the execute unit's data accesses have priority
- byte_valid  out  1  queue head holds a byte
- byte_data  out  8  head byte
- byte_addr  out  16  memory address of head byte
- byte_pop  in  1  decoder consumes head this cycle
- redirect  in  1  control transfer (jump/branch/return)
- redirect_pc  in  16  new fetch address
- halt  in  1  stop fetching (HLT decoded)
- halted  out  1  fetch stopped flag

Behaviour:
- Reset (synchronous, overrides everything):
  - fetch_pc = RESET_PC, count = 0, rd/wr pointers = 0, halted = 0.
  - Outputs at reset: byte_valid = 0, bus_req = 1, Direccion = RESET_PC.
  - byte_data and byte_addr are don't-care while byte_valid = 0.
- bus_req = ~halted & (count < DEPTH). Combinational from registered state only; no path from byte_pop or bus_gnt.
- fire = bus_req & bus_gnt.
  - On the rising edge with fire: push {fetch_pc, Datos} at wr_ptr; fetch_pc <= fetch_pc + 1.
  - Address arithmetic is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - Latency: a byte fetched at edge N is visible on byte_valid/byte_data in cycle N+1.
- pop = byte_valid & byte_pop.
  - Advances rd_ptr.
  - byte_pop while empty is ignored and is not an error.
- Simultaneous fire and pop: count is unchanged and both pointers advance.
  - At full, no fire is possible that cycle, because bus_req was already low.
  - A pop at full raises bus_req in the following cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- byte_valid = (count != 0). byte_data/byte_addr come from a direct read of the queue head; no extra register stage.
- redirect (priority over fire, pop and halt in the same cycle):
  - Flush the queue (count = 0, pointers = 0).
  - fetch_pc <= redirect_pc; halted <= 0.
  - Any fire in that cycle is discarded: no push, fetch_pc not incremented.
  - Next cycle: byte_valid = 0, Direccion = redirect_pc, bus_req = 1.
- halt:
  - halted <= 1 at the edge where halt is high and redirect is low. The flag is sticky until redirect or reset.
  - A fire in the halt cycle still completes.
  - While halted, the queue keeps draining via pop.
- bus_gnt low: no fetch, fetch_pc holds, Direccion holds. The block must not sample Datos.
- Reset mid-operation discards all queued bytes; the first post-reset fetch is at RESET_PC.

Decomposition:
- Shared package cpucr_pkg: ADDR_W, DATA_W, reset vector constant, and the queue entry struct {addr[15:0], data[7:0]}. The opcode mnemonics already live in the shared decode include.
- One sub-module: cpucr_byte_fifo.
  - Parameterised by DEPTH.
  - Synchronous push/pop/flush.
  - Outputs count and head.
- cpucr_prefetch holds fetch_pc, halted, and the request/redirect logic.

Test Plan:
- Reset, bus_gnt = 1, memory 0000:{8'h10,8'h01,8'h20,8'h30}, byte_pop = 0 → 4 pushes at 0000..0003; count 4; bus_req = 0; Direccion = 0004; head = 8'h10 @ 0000.
- Full queue, byte_pop = 1 for one cycle → next cycle bus_req = 1; fetch of 0004 fires; count stays 4; head = 8'h01 @ 0001.
- Steady state, bus_gnt = 1, byte_pop = 1 every cycle → one byte per cycle in address order; byte_addr increments by 1; count constant.
- Redirect to 16'hFF00 in the same cycle as a pop and a grant → queue empty next cycle; Direccion = FF00; first byte returned is mem[FF00] (e.g. 8'h2F) with byte_addr FF00.
- fetch_pc = FFFE, continuous grant and pop → byte_addr sequence FFFE, FFFF, 0000, 0001.
- Assert halt with 2 bytes queued, bus_gnt = 1 → halted = 1 and bus_req = 0 next cycle; the 2 bytes still drain; then redirect to 0005 → halted = 0 and fetch resumes at 0005.
- bus_gnt toggled 0/1 in alternate cycles → pushes only on granted edges; no duplicate or skipped addresses.
